tt_tile_bist: RTL and testbench
===============================

# tt_tile_bist

Parametrised, synthesizable built-in self-test engine for tile designs with a ui_in/uo_out style port pair. It drives pseudo-random stimulus vectors from a Galois LFSR onto the tile's input bus and waits a programmable settle time. It then compacts the tile's output bus into a multiple-input signature register (MISR) and reports pass/fail against an expected signature. It sits between the tile under test and the harness, replacing hand-written vector sequences with a single start/done handshake.

## Interface
- WIDTH, 8: width of stimulus bus, response bus, LFSR and MISR (≥2).
- N_VECTORS, 256: vectors applied per run (≥1).
- SETTLE, 1: cycles each vector is held before its response is sampled (≥1).
- POLY, 8'h1D: Galois feedback taps, WIDTH bits, shared by LFSR and MISR.
- SEED, 8'h01: LFSR initial value, WIDTH bits. A SEED of 0 is replaced by 1.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE and DONE only.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- expected  in  WIDTH  golden signature; must be stable while done=1.
- dut_out  in  WIDTH  response from tile (uo_out).
- dut_in  out  WIDTH  stimulus to tile (ui_in).
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done && (signature == expected); combinational from registers.
- signature  out  WIDTH  current MISR contents.
- vec_count  out  clog2(N_VECTORS+1)  vectors sampled in this run.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, dut_in=0, lfsr=SEED (or 1), misr=0, vec_count=0, settle counter=0, busy=done=pass=0.
- IDLE/DONE + start: load lfsr=SEED, misr=0, vec_count=0, settle=0. Go to RUN. dut_in=SEED from the next cycle.
- RUN: dut_in = lfsr (registered). Settle counter increments each cycle. On the edge where the counter reaches SETTLE-1:
  - misr ← galois(misr) ^ dut_out
  - lfsr ← galois(lfsr)
  - vec_count += 1
  - settle counter ← 0
- galois(x) = {x[WIDTH-2:0],0} ^ (x[WIDTH-1] ? POLY : 0). Widths are fixed at WIDTH; no carry out.
- Last sample (vec_count reaches N_VECTORS on that edge): go to DONE. dut_in ← 0.
- DONE: done=1. signature and vec_count hold. pass is valid.
- start in RUN is ignored.
- abort has priority over start and over sampling. On abort: go to IDLE, dut_in=0, done=0. misr, lfsr and vec_count keep their values for debug.
- Simultaneous abort+start in IDLE/DONE: abort wins, and the block stays in or goes to IDLE.
- Reset asserted mid-run: immediate return to reset values. No partial signature survives.

## Timing
- Start asserted in cycle t: busy=1 and dut_in=SEED visible from t+1.
- Vector k (0-based) is driven during cycles t+1+k·SETTLE … t+(k+1)·SETTLE.
- Vector k's response is sampled on the rising edge that ends cycle t+(k+1)·SETTLE. The next vector appears on that same edge.
- Run length: N_VECTORS·SETTLE cycles in RUN. done=1 from cycle t+1+N_VECTORS·SETTLE.
- The tile's combinational path dut_in→dut_out must resolve within SETTLE cycles.
- Back-to-back runs: start held in DONE restarts on the next edge, and done drops the same edge.

## Test plan
- Defaults except N_VECTORS=4, dut_out=~dut_in (combinational) -> dut_in sequence 01,02,04,08; signature=6C. With expected=6C: pass=1. With expected=6D: pass=0.
- Same, loopback dut_out=dut_in -> signature=00, vec_count=4, done at cycle t+5.
- SETTLE=3, N_VECTORS=4, dut_out=~dut_in -> each vector held 3 cycles, signature=6C, done at cycle t+13.
- abort pulsed after 2 samples -> state IDLE next cycle; dut_in=0, busy=0, done=0, vec_count=2. A fresh start reproduces signature 6C.
- rst_n dropped mid-RUN, asynchronously between edges -> outputs immediately at reset values (dut_in=0, signature=0, busy=0).
- SEED=0 -> first driven vector is 01. In DONE, start+abort together -> IDLE and no restart.

Source files
------------

// File: rtl/tt_tile_bist.sv
// rtl/tt_tile_bist.sv - LFSR-stimulus / MISR-compaction built-in self-test engine for a tile
//
// Purpose:
//   Drives pseudo-random vectors from a Galois LFSR onto a tile's input bus.
//   Holds each vector for SETTLE cycles, then folds the tile's response into a
//   Galois MISR. After N_VECTORS samples it reports the signature and pass/fail
//   against a golden value. The run is controlled by a start/done handshake.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (honoured in IDLE and DONE)
//   abort      in   synchronous abort to IDLE (beats start and sampling)
//   expected   in   golden signature
//   dut_out    in   tile response (uo_out)
//   dut_in     out  tile stimulus (ui_in), registered
//   busy       out  run in progress
//   done       out  run complete, signature valid
//   pass       out  done and signature matches expected
//   signature  out  current MISR contents
//   vec_count  out  vectors sampled in this run

module tt_tile_bist #(
    parameter int               WIDTH     = 8,
    parameter int               N_VECTORS = 256,
    parameter int               SETTLE    = 1,
    parameter logic [WIDTH-1:0] POLY      = 8'h1D,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    localparam int              CW        = $clog2(N_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] dut_out,
    output logic [WIDTH-1:0] dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CW-1:0]    vec_count
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF =
        (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    localparam logic [CW-1:0] LAST_VEC    = CW'(N_VECTORS - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] dut_in_q,    dut_in_d;
    logic [WIDTH-1:0] lfsr_q,      lfsr_d;
    logic [WIDTH-1:0] misr_q,      misr_d;
    logic [CW-1:0]    vec_count_q, vec_count_d;
    logic [SW-1:0]    settle_q,    settle_d;

    // Shift left, fold the dropped MSB back through the taps.
    function automatic logic [WIDTH-1:0] galois(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dut_in_q    <= '0;
            lfsr_q      <= SEED_EFF;
            misr_q      <= '0;
            vec_count_q <= '0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            dut_in_q    <= dut_in_d;
            lfsr_q      <= lfsr_d;
            misr_q      <= misr_d;
            vec_count_q <= vec_count_d;
            settle_q    <= settle_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dut_in_d    = dut_in_q;
        lfsr_d      = lfsr_q;
        misr_d      = misr_q;
        vec_count_d = vec_count_q;
        settle_d    = settle_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    // lfsr, misr and vec_count are left alone for debug.
                    state_d  = ST_IDLE;
                    dut_in_d = '0;
                    settle_d = '0;
                end else if (start) begin
                    state_d     = ST_RUN;
                    lfsr_d      = SEED_EFF;
                    misr_d      = '0;
                    vec_count_d = '0;
                    settle_d    = '0;
                    dut_in_d    = SEED_EFF;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    dut_in_d = '0;
                    settle_d = '0;
                end else if (settle_q == LAST_SETTLE) begin
                    // Sample edge: compact the response and advance to the next
                    // vector on the same edge.
                    misr_d      = galois(misr_q) ^ dut_out;
                    lfsr_d      = galois(lfsr_q);
                    vec_count_d = vec_count_q + CW'(1);
                    settle_d    = '0;
                    if (vec_count_q == LAST_VEC) begin
                        state_d  = ST_DONE;
                        dut_in_d = '0;
                    end else begin
                        dut_in_d = galois(lfsr_q);
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                dut_in_d = '0;
                settle_d = '0;
            end
        endcase
    end

    assign dut_in    = dut_in_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = (state_q == ST_DONE) && (misr_q == expected);
    assign signature = misr_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_tt_tile_bist.sv
// tb/tb_tt_tile_bist.sv - scoreboard bench for tt_tile_bist (SETTLE=1 and SETTLE=3/SEED=0 instances)

module tb_tt_tile_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    // instance a: defaults, N_VECTORS=4, selectable inverting/loopback tile
    logic       start_a = 1'b0, abort_a = 1'b0, inv_a = 1'b1;
    logic [7:0] expected_a = 8'h00;
    logic [7:0] dut_in_a, dut_out_a, sig_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] vc_a;

    // instance b: SETTLE=3, SEED=0, N_VECTORS=4, inverting tile
    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [7:0] expected_b = 8'h00;
    logic [7:0] dut_in_b, dut_out_b, sig_b;
    logic       busy_b, done_b, pass_b;
    logic [2:0] vc_b;

    assign dut_out_a = inv_a ? ~dut_in_a : dut_in_a;
    assign dut_out_b = ~dut_in_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_tile_bist #(.WIDTH(8), .N_VECTORS(4), .SETTLE(1), .POLY(8'h1D), .SEED(8'h01)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .expected(expected_a), .dut_out(dut_out_a), .dut_in(dut_in_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a), .vec_count(vc_a)
    );

    tt_tile_bist #(.WIDTH(8), .N_VECTORS(4), .SETTLE(3), .POLY(8'h1D), .SEED(8'h00)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .expected(expected_b), .dut_out(dut_out_b), .dut_in(dut_in_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b), .vec_count(vc_b)
    );

    typedef struct {
        logic [7:0] sig;
        int         vc;
        logic       ps;
        int         at;
    } res_t;

    logic [7:0] vec_q_a[$];
    logic [7:0] vec_q_b[$];
    res_t       res_q_a[$];
    res_t       res_q_b[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic res_t mk_res(input logic [7:0] s, input int v, input logic p, input int at);
        res_t r;
        r.sig = s;
        r.vc  = v;
        r.ps  = p;
        r.at  = at;
        return r;
    endfunction

    // Expected stimulus vector, one entry per busy cycle.
    task automatic push_vec(input int which, input logic [7:0] v, input int reps);
        for (int i = 0; i < reps; i++) begin
            if (which == 0) vec_q_a.push_back(v);
            else            vec_q_b.push_back(v);
        end
    endtask

    task automatic push_run(input int which, input int reps);
        push_vec(which, 8'h01, reps);
        push_vec(which, 8'h02, reps);
        push_vec(which, 8'h04, reps);
        push_vec(which, 8'h08, reps);
    endtask

    task automatic wait_done(input int which);
        int n;
        n = 0;
        while (((which == 0) ? done_a : done_b) == 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (((which == 0) ? done_a : done_b) == 1'b0) begin
            checks++;
            failures++;
            $display("FAIL wait_done%0d actual=timeout required=done", which);
        end
    endtask

    // ---------------- monitors ----------------
    logic done_a_prev = 1'b0;
    logic done_b_prev = 1'b0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (busy_a) begin
            if (vec_q_a.size() == 0) chk("vec_a_unexpected", int'(dut_in_a), -1);
            else begin
                e = vec_q_a.pop_front();
                chk("vec_a", int'(dut_in_a), int'(e));
            end
        end
        if (busy_b) begin
            if (vec_q_b.size() == 0) chk("vec_b_unexpected", int'(dut_in_b), -1);
            else begin
                e = vec_q_b.pop_front();
                chk("vec_b", int'(dut_in_b), int'(e));
            end
        end
    end

    always @(negedge clk) begin
        res_t r;
        if (done_a && !done_a_prev) begin
            if (res_q_a.size() == 0) chk("res_a_unexpected", 1, 0);
            else begin
                r = res_q_a.pop_front();
                chk("sig_a", int'(sig_a), int'(r.sig));
                chk("vc_a", int'(vc_a), r.vc);
                chk("pass_a", int'(pass_a), int'(r.ps));
                chk("done_cyc_a", cyc, r.at);
            end
        end
        if (done_b && !done_b_prev) begin
            if (res_q_b.size() == 0) chk("res_b_unexpected", 1, 0);
            else begin
                r = res_q_b.pop_front();
                chk("sig_b", int'(sig_b), int'(r.sig));
                chk("vc_b", int'(vc_b), r.vc);
                chk("pass_b", int'(pass_b), int'(r.ps));
                chk("done_cyc_b", cyc, r.at);
            end
        end
        done_a_prev = done_a;
        done_b_prev = done_b;
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dut_in", int'(dut_in_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_pass", int'(pass_a), 0);
        chk("rst_sig", int'(sig_a), 0);
        chk("rst_vc", int'(vc_a), 0);
        rst_n = 1'b1;

        // inverting tile, expected 6C
        @(negedge clk);
        inv_a = 1'b1;
        expected_a = 8'h6C;
        push_run(0, 1);
        res_q_a.push_back(mk_res(8'h6C, 4, 1'b1, cyc + 5));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0);

        // wrong golden value, then back-to-back restart from DONE
        @(negedge clk);
        expected_a = 8'h6D;
        #1;
        chk("pass_with_6d", int'(pass_a), 0);
        chk("done_hold", int'(done_a), 1);
        push_run(0, 1);
        res_q_a.push_back(mk_res(8'h6C, 4, 1'b0, cyc + 5));
        start_a = 1'b1;
        @(negedge clk);
        chk("restart_done_drop", int'(done_a), 0);
        chk("restart_busy", int'(busy_a), 1);
        start_a = 1'b0;
        wait_done(0);

        // loopback tile
        @(negedge clk);
        inv_a = 1'b0;
        expected_a = 8'h00;
        push_run(0, 1);
        res_q_a.push_back(mk_res(8'h00, 4, 1'b1, cyc + 5));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0);

        // abort after two samples
        @(negedge clk);
        inv_a = 1'b1;
        push_vec(0, 8'h01, 1);
        push_vec(0, 8'h02, 1);
        push_vec(0, 8'h04, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_dut_in", int'(dut_in_a), 0);
        chk("abort_vc", int'(vc_a), 2);
        chk("abort_sig_kept", int'(sig_a), 8'h1C);

        // fresh run after abort
        expected_a = 8'h6C;
        push_run(0, 1);
        res_q_a.push_back(mk_res(8'h6C, 4, 1'b1, cyc + 5));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0);

        // start+abort together in DONE
        @(negedge clk);
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("sa_busy", int'(busy_a), 0);
        chk("sa_done", int'(done_a), 0);
        chk("sa_pass", int'(pass_a), 0);
        @(negedge clk);
        chk("sa_no_restart", int'(busy_a), 0);
        chk("sa_sig_kept", int'(sig_a), 8'h6C);

        // SETTLE=3, SEED=0 instance
        expected_b = 8'h6C;
        push_run(1, 3);
        res_q_b.push_back(mk_res(8'h6C, 4, 1'b1, cyc + 13));
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1);

        // asynchronous reset mid-run
        @(negedge clk);
        push_vec(0, 8'h01, 1);
        push_vec(0, 8'h02, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dut_in", int'(dut_in_a), 0);
        chk("arst_sig", int'(sig_a), 0);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_vc", int'(vc_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("vec_q_a_left", vec_q_a.size(), 0);
        chk("vec_q_b_left", vec_q_b.size(), 0);
        chk("res_q_a_left", res_q_a.size(), 0);
        chk("res_q_b_left", res_q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
